// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default bit period
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // 25 MHz / 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
    localparam int unsigned DATA_WIDTH_MAX       = 9;

    function automatic logic even_parity(input logic [DATA_WIDTH_MAX-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// valid/yumi stream link between an elastic pipeline stage (master) and the
// UART transmitter (slave) that consumes one word per frame.
interface uart_tx_serializer_if #(
    parameter int unsigned data_width_p = 8
) ();

    logic                    valid_i;
    logic [data_width_p-1:0] data_i;
    logic                    yumi_o;

    modport master (
        output valid_i,
        output data_i,
        input  yumi_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
        output yumi_o
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..clks_per_bit_p-1 while enabled and flags the
// terminal count. Shared between the UART transmitter and receiver.
module uart_baud_counter import uart_pkg::*; #(
    parameter int unsigned clks_per_bit_p = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned            cnt_w_lp    = (clks_per_bit_p > 1) ? $clog2(clks_per_bit_p) : 1;
    localparam logic [cnt_w_lp-1:0]    terminal_lp = cnt_w_lp'(clks_per_bit_p - 1);

    logic [cnt_w_lp-1:0] r_count;
    logic                w_terminal;

    assign w_terminal = (r_count == terminal_lp);
    assign tick_o     = en_i & w_terminal;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
            r_count <= '0;
        end else if (en_i) begin
            r_count <= w_terminal ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter consuming a valid/yumi stream: start bit, data LSB first,
// optional even parity, then one or two stop bits on a registered tx line.
module uart_tx_serializer import uart_pkg::*; #(
    parameter int unsigned data_width_p   = 8,
    parameter int unsigned clks_per_bit_p = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned parity_en_p    = 0,
    parameter int unsigned stop_bits_p    = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    uart_tx_serializer_if.slave  up_if,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int unsigned          idx_w_lp         = $clog2(data_width_p + 1);
    localparam logic [idx_w_lp-1:0]  last_data_idx_lp = idx_w_lp'(data_width_p - 1);
    localparam logic [idx_w_lp-1:0]  last_stop_idx_lp = idx_w_lp'(stop_bits_p - 1);

    uart_tx_state_e          r_state, w_next_state;
    logic                    r_tx, w_tx_next;
    logic [data_width_p-1:0] r_shift, w_shift_next;
    logic                    r_parity, w_parity_next;
    logic [idx_w_lp-1:0]     r_bit_idx, w_bit_idx_next;
    logic                    w_yumi;
    logic                    w_busy;
    logic                    w_tick;

    // reset_ni gates yumi so an undriven valid_i during reset never leaks upstream
    assign w_yumi       = (r_state == IDLE) & up_if.valid_i & reset_ni;
    assign w_busy       = (r_state != IDLE);
    assign up_if.yumi_o = w_yumi;
    assign tx_o         = r_tx;
    assign busy_o       = w_busy;

    uart_baud_counter #(
        .clks_per_bit_p (clks_per_bit_p)
    ) u_baud (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (w_yumi),
        .en_i     (w_busy),
        .tick_o   (w_tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_next_state   = r_state;
        w_tx_next      = r_tx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_idx_next = r_bit_idx;

        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_yumi) begin
                    w_next_state   = START;
                    w_tx_next      = 1'b0;
                    w_shift_next   = up_if.data_i;
                    w_parity_next  = even_parity(DATA_WIDTH_MAX'(up_if.data_i));
                    w_bit_idx_next = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == last_data_idx_lp) begin
                        w_bit_idx_next = '0;
                        if (parity_en_p != 0) begin
                            w_next_state = PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_next_state = STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_next_state   = STOP;
                    w_tx_next      = 1'b1;
                    w_bit_idx_next = '0;
                end
            end
            STOP: begin
                // r_bit_idx is reused here to count stop bits
                if (w_tick) begin
                    if (r_bit_idx == last_stop_idx_lp) begin
                        w_next_state   = IDLE;
                        w_bit_idx_next = '0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_tx      <= w_tx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_bit_idx <= w_bit_idx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two configurations, a frame-level
// reference model, a behavioural elastic stage and a bench-side UART decoder.
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_serializer_if #(.data_width_p(DW)) if_a ();
    uart_tx_serializer_if #(.data_width_p(DW)) if_b ();

    logic tx_a, busy_a, tx_b, busy_b;

    uart_tx_serializer #(
        .data_width_p(DW), .clks_per_bit_p(CPB), .parity_en_p(0), .stop_bits_p(1)
    ) dut_a (
        .clk_i(clk), .reset_ni(rst_n), .up_if(if_a), .tx_o(tx_a), .busy_o(busy_a)
    );

    uart_tx_serializer #(
        .data_width_p(DW), .clks_per_bit_p(CPB), .parity_en_p(1), .stop_bits_p(2)
    ) dut_b (
        .clk_i(clk), .reset_ni(rst_n), .up_if(if_b), .tx_o(tx_b), .busy_o(busy_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic cap_tx   [0:63];
    logic cap_busy [0:63];
    logic cap_yumi [0:63];

    // ---------------- reference model ----------------
    function automatic int ref_len(input int par, input int stop);
        return (1 + DW + par + stop) * CPB;
    endfunction

    // expected line level k cycles after the accept cycle (k=1 is the first start-bit cycle)
    function automatic logic ref_tx(input logic [7:0] data, input int k, input int par, input int stop);
        int b;
        if (k < 1 || k > ref_len(par, stop)) return 1'b1;
        b = (k - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return data[b-1];
        if (par != 0 && b == DW + 1) return ^data;
        return 1'b1;
    endfunction

    // ---------------- access helpers ----------------
    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_yumi(input int sel);
        return (sel == 0) ? if_a.yumi_o : if_b.yumi_o;
    endfunction

    task automatic drive(input int sel, input logic valid, input logic [7:0] data);
        if (sel == 0) begin
            if_a.valid_i = valid;
            if_a.data_i  = data;
        end else begin
            if_b.valid_i = valid;
            if_b.data_i  = data;
        end
    endtask

    task automatic wait_yumi(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (get_yumi(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input int sel, input logic [7:0] data, output bit ok);
        @(posedge clk); #1;
        drive(sel, 1'b1, data);
        wait_yumi(sel, ok);
    endtask

    // records cycles 1..len+1 after the accept cycle; valid drops after the accept edge
    task automatic capture_frame(input int sel, input int len, input bit toggle);
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(sel, 1'b0, 8'h00);
            if (toggle) drive(sel, 1'b0, 8'($urandom));
            @(negedge clk);
            cap_tx[k]   = get_tx(sel);
            cap_busy[k] = get_busy(sel);
            cap_yumi[k] = get_yumi(sel);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if_a.valid_i = 1'bx; if_a.data_i = 'x;
        if_b.valid_i = 1'bx; if_b.data_i = 'x;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            tests_run++;
            if (get_yumi(s) !== 1'b0) begin
                tests_failed++; $display("FAIL reset_yumi dut%0d: got %b expected 0", s, get_yumi(s));
            end
            tests_run++;
            if (get_tx(s) !== 1'b1) begin
                tests_failed++; $display("FAIL reset_tx dut%0d: got %b expected 1", s, get_tx(s));
            end
            tests_run++;
            if (get_busy(s) !== 1'b0) begin
                tests_failed++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, get_busy(s));
            end
        end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_frame_a5();
        bit ok;
        int errs = 0;
        int busy_cnt = 0;
        logic [9:0] seq = 10'b1101001010;
        send(0, 8'hA5, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL a5_yumi: got no yumi within 50 cycles, expected one");
            return;
        end
        capture_frame(0, 40, 1'b0);
        for (int k = 1; k <= 41; k++) begin
            if (cap_tx[k] !== ref_tx(8'hA5, k, 0, 1) || cap_busy[k] !== (k <= 40) || cap_yumi[k] !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL a5_frame cycle %0d: got tx=%b busy=%b yumi=%b expected tx=%b busy=%b yumi=0",
                             k, cap_tx[k], cap_busy[k], cap_yumi[k], ref_tx(8'hA5, k, 0, 1), (k <= 40));
                errs++;
            end
            if (cap_busy[k] === 1'b1) busy_cnt++;
        end
        tests_run++;
        if (errs != 0) tests_failed++;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (cap_tx[i*CPB + 2] !== seq[i]) begin
                tests_failed++; $display("FAIL a5_bit%0d: got %b expected %b", i, cap_tx[i*CPB+2], seq[i]);
            end
        end
        tests_run++;
        if (busy_cnt != 40) begin
            tests_failed++; $display("FAIL a5_busy_len: got %0d expected 40", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic tr_tx [0:81];
        logic tr_y  [0:81];
        int errs = 0;
        int second = -1;
        int run = 0;
        logic exp_tx;
        send(0, 8'h00, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL b2b_first_yumi: got no yumi, expected one");
            drive(0, 1'b0, 8'h00);
            return;
        end
        for (int c = 0; c < 82; c++) begin
            tr_tx[c] = tx_a;
            tr_y[c]  = if_a.yumi_o;
            @(posedge clk); #1;
            if (c == 0) drive(0, 1'b1, 8'hFF);
            if (c > 0 && tr_y[c] === 1'b1) drive(0, 1'b0, 8'hFF);
            if (c < 81) @(negedge clk);
        end
        for (int c = 1; c < 82; c++)
            if (tr_y[c] === 1'b1 && second < 0) second = c;
        tests_run++;
        if (second != 41) begin
            tests_failed++; $display("FAIL b2b_period: got %0d expected 41", second);
        end
        for (int c = 1; c < 82; c++) begin
            if (c <= 40)      exp_tx = ref_tx(8'h00, c, 0, 1);
            else if (c == 41) exp_tx = 1'b1;
            else              exp_tx = ref_tx(8'hFF, c - 41, 0, 1);
            if (tr_tx[c] !== exp_tx || tr_y[c] !== (c == 41)) begin
                if (errs == 0)
                    $display("FAIL b2b_trace cycle %0d: got tx=%b yumi=%b expected tx=%b yumi=%b",
                             c, tr_tx[c], tr_y[c], exp_tx, (c == 41));
                errs++;
            end
        end
        tests_run++;
        if (errs != 0) tests_failed++;
        for (int c = 41; c > 0 && tr_tx[c] === 1'b1; c--) run++;
        tests_run++;
        if (run != CPB + 1) begin
            tests_failed++; $display("FAIL b2b_gap_high: got %0d expected %0d", run, CPB + 1);
        end
        errs = 0;
        for (int b = 1; b <= DW; b++)
            if (tr_tx[41 + b*CPB + 2] !== 1'b1) errs++;
        tests_run++;
        if (errs != 0) begin
            tests_failed++; $display("FAIL b2b_ff_bits: got %0d zero bits expected 0", errs);
        end
    endtask

    task automatic test_parity(input logic [7:0] data, input logic exp_par, input bit explicit);
        bit ok;
        int errs = 0;
        send(1, data, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL par_yumi %h: got no yumi, expected one", data);
            drive(1, 1'b0, 8'h00);
            return;
        end
        capture_frame(1, 48, 1'b0);
        for (int k = 1; k <= 49; k++) begin
            if (cap_tx[k] !== ref_tx(data, k, 1, 2) || cap_busy[k] !== (k <= 48)) begin
                if (errs == 0)
                    $display("FAIL par_frame %h cycle %0d: got tx=%b busy=%b expected tx=%b busy=%b",
                             data, k, cap_tx[k], cap_busy[k], ref_tx(data, k, 1, 2), (k <= 48));
                errs++;
            end
        end
        tests_run++;
        if (errs != 0) tests_failed++;
        if (explicit) begin
            tests_run++;
            if (cap_tx[9*CPB + 2] !== exp_par) begin
                tests_failed++; $display("FAIL par_bit %h: got %b expected %b", data, cap_tx[9*CPB+2], exp_par);
            end
            errs = 0;
            for (int k = 41; k <= 48; k++) if (cap_tx[k] !== 1'b1) errs++;
            tests_run++;
            if (errs != 0 || cap_busy[48] !== 1'b1 || cap_busy[49] !== 1'b0) begin
                tests_failed++;
                $display("FAIL par_stop %h: got %0d low stop cycles, busy48=%b busy49=%b expected 0,1,0",
                         data, errs, cap_busy[48], cap_busy[49]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int errs = 0;
        logic [7:0] d1 = 8'($urandom);
        logic [7:0] d2 = 8'($urandom);
        send(0, d1, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL rst_mid_yumi: got no yumi, expected one");
            drive(0, 1'b0, 8'h00);
            return;
        end
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 1) drive(0, 1'b0, 8'h00);
            @(negedge clk);
        end
        tests_run++;
        if (tx_a !== d1[3]) begin
            tests_failed++; $display("FAIL rst_mid_bit3: got %b expected %b", tx_a, d1[3]);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_async: got tx=%b busy=%b expected tx=1 busy=0", tx_a, busy_a);
        end
        drive(0, 1'b1, d2);
        #1;
        tests_run++;
        if (if_a.yumi_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_yumi_gated: got %b expected 0", if_a.yumi_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (if_a.yumi_o !== 1'b1) begin
            tests_failed++; $display("FAIL rst_mid_release_yumi: got %b expected 1", if_a.yumi_o);
        end
        capture_frame(0, 40, 1'b0);
        for (int k = 1; k <= 41; k++)
            if (cap_tx[k] !== ref_tx(d2, k, 0, 1) || cap_busy[k] !== (k <= 40)) begin
                if (errs == 0)
                    $display("FAIL rst_mid_fresh cycle %0d: got tx=%b busy=%b expected tx=%b busy=%b",
                             k, cap_tx[k], cap_busy[k], ref_tx(d2, k, 0, 1), (k <= 40));
                errs++;
            end
        tests_run++;
        if (errs != 0) tests_failed++;
    endtask

    task automatic test_idle();
        int errs = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 8'($urandom));
            @(negedge clk);
            if (if_a.yumi_o !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL idle cycle %0d: got yumi=%b tx=%b busy=%b expected 0,1,0",
                             c, if_a.yumi_o, tx_a, busy_a);
                errs++;
            end
        end
        tests_run++;
        if (errs != 0) tests_failed++;
    endtask

    task automatic test_data_toggle();
        bit ok;
        int errs = 0;
        logic [7:0] d = 8'($urandom);
        send(0, d, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL toggle_yumi: got no yumi, expected one");
            drive(0, 1'b0, 8'h00);
            return;
        end
        capture_frame(0, 40, 1'b1);
        for (int k = 1; k <= 41; k++)
            if (cap_tx[k] !== ref_tx(d, k, 0, 1)) begin
                if (errs == 0)
                    $display("FAIL toggle_frame cycle %0d: got %b expected %b", k, cap_tx[k], ref_tx(d, k, 0, 1));
                errs++;
            end
        tests_run++;
        if (errs != 0) tests_failed++;
        drive(0, 1'b0, 8'h00);
    endtask

    task automatic test_pipeline_random();
        logic [7:0] bytes [16];
        logic [7:0] got [$];
        logic [7:0] stage = 8'h00;
        logic [7:0] dec_byte = 8'h00;
        bit full = 1'b0;
        bit prev_yumi = 1'b0;
        bit dec_active = 1'b0;
        int dec_cnt = 0;
        int pushed = 0;
        int stop_errs = 0;
        int b;
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 16 * 41 + 100 && got.size() < 16; cyc++) begin
            if (prev_yumi) full = 1'b0;
            if (!full && pushed < 16) begin
                full  = 1'b1;
                stage = bytes[pushed];
                pushed++;
            end
            drive(0, full, stage);
            @(negedge clk);
            prev_yumi = (if_a.yumi_o === 1'b1);
            if (!dec_active) begin
                if (tx_a === 1'b0) begin
                    dec_active = 1'b1;
                    dec_cnt    = 0;
                end
            end else begin
                dec_cnt++;
                if (dec_cnt % CPB == CPB / 2) begin
                    b = dec_cnt / CPB;
                    if (b >= 1 && b <= DW) begin
                        dec_byte[b-1] = tx_a;
                    end else if (b == DW + 1) begin
                        if (tx_a !== 1'b1) stop_errs++;
                        got.push_back(dec_byte);
                        dec_active = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 8'h00);
        tests_run++;
        if (got.size() != 16) begin
            tests_failed++; $display("FAIL pipe_count: got %0d bytes expected 16", got.size());
        end
        tests_run++;
        if (stop_errs != 0) begin
            tests_failed++; $display("FAIL pipe_stop: got %0d bad stop bits expected 0", stop_errs);
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== bytes[i]) begin
                tests_failed++; $display("FAIL pipe_byte%0d: got %h expected %h", i, got[i], bytes[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_a5();
        repeat (3) @(posedge clk);
        test_back_to_back();
        repeat (3) @(posedge clk);
        test_parity(8'h07, 1'b1, 1'b1);
        test_parity(8'h03, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) test_parity(8'($urandom), 1'b0, 1'b0);
        test_reset_mid_frame();
        test_idle();
        test_data_toggle();
        repeat (3) @(posedge clk);
        test_pipeline_random();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
